reg_wb_arbiter: RTL

Write-back arbiter for the 32x32 register file (`REG`). It shares the register file's single write port between two write-back requesters: requester 0 is the ALU path and requester 1 is the load/long-latency path. Each requester has a small FIFO, and the arbiter drains the FIFOs round-robin at one write per clock. Its registered outputs drive `REG_write_1`, `REG_address_wr` and `REG_data_wb_in1` directly.

---
 rtl/reg_wb_arbiter_if.sv | 38 +++
 rtl/reg_wb_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus bundle: both requester FIFO handshakes, the register-file
// write port and the occupancy counts, with arbiter (slave) and client (master) views.
interface reg_wb_arbiter_if #(
  parameter int CW = 4
);
  logic          req0_valid;
  logic          req0_ready;
  logic [4:0]    req0_addr;
  logic [31:0]   req0_data;

  logic          req1_valid;
  logic          req1_ready;
  logic [4:0]    req1_addr;
  logic [31:0]   req1_data;

  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;

  logic [CW-1:0] occ0;
  logic [CW-1:0] occ1;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data,
    input  occ0, occ1
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data,
    output occ0, occ1
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter: two small FIFOs (ALU path, load path)
// drained one entry per clock into the register file's single write port.
module reg_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  reg_wb_arbiter_if.slave bus
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [1:0]    in_valid;
  logic [4:0]    in_addr [2];
  logic [31:0]   in_data [2];

  logic [CW-1:0] occ  [2];
  logic [PW-1:0] rptr [2];
  logic [PW-1:0] wptr [2];
  logic [36:0]   mem  [2][DEPTH];

  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    elig;
  logic          grant_en;
  logic          grant_sel;
  logic          last;
  logic [36:0]   head;

  logic          wr_en_q;
  logic [4:0]    wr_addr_q;
  logic [31:0]   wr_data_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign in_valid   = {bus.req1_valid, bus.req0_valid};
  assign in_addr[0] = bus.req0_addr;
  assign in_addr[1] = bus.req1_addr;
  assign in_data[0] = bus.req0_data;
  assign in_data[1] = bus.req1_data;

  // Ready looks only at occupancy, so a full FIFO refuses even when it pops this edge.
  always_comb begin
    ready = '0;
    push  = '0;
    elig  = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i] = !reset && (occ[i] < DEPTH_C);
      push[i]  = in_valid[i] && ready[i] && (in_addr[i] != 5'd0);
      elig[i]  = (occ[i] != '0);
    end
  end

  // On a tie the requester not granted last time wins.
  always_comb begin
    grant_en  = !hold && (elig != 2'b00);
    grant_sel = (elig == 2'b11) ? ~last : elig[1];
    pop       = 2'b00;
    if (grant_en) begin
      pop = grant_sel ? 2'b10 : 2'b01;
    end
    head = mem[grant_sel][rptr[grant_sel]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem[i][wptr[i]] <= {in_addr[i], in_data[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        occ[i]  <= '0;
        rptr[i] <= '0;
        wptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wptr[i] <= next_ptr(wptr[i]);
        end
        if (pop[i]) begin
          rptr[i] <= next_ptr(rptr[i]);
        end
        case ({push[i], pop[i]})
          2'b10:   occ[i] <= occ[i] + CW'(1);
          2'b01:   occ[i] <= occ[i] - CW'(1);
          default: occ[i] <= occ[i];
        endcase
      end
    end
  end

  // Address and data keep their last value when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last      <= 1'b1;
    end else if (grant_en) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= head[36:32];
      wr_data_q <= head[31:0];
      last      <= grant_sel;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.occ0       = occ[0];
  assign bus.occ1       = occ[1];

endmodule
